mem_bridge: RTL and testbench

Multicycle-datapath memory bridge sitting directly downstream of the control FSM: it consumes `iOrD`, `memRead`, `memWrite` and `irWrite`, and turns each request into a single transaction on an external req/ack memory bus. It holds the Instruction Register (IR) and the Memory Data Register (MDR), and asserts `stall` so the FSM holds its state while a transaction is outstanding. One transaction is in flight at most.

---
 rtl/mips_pkg.sv | 14 +
 rtl/bus_watchdog.sv | 32 +++
 rtl/mem_bridge.sv | 125 ++++++++++++
 tb/tb_mem_bridge.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle datapath: bridge state type and memory constants.
package mips_pkg;

  typedef enum logic {
    StIdle,
    StWait
  } bridge_state_e;

  // A zero word decodes as a NOP, so an aborted fetch is harmless.
  localparam logic [31:0] NOP_WORD = 32'h0;

  localparam int unsigned MEM_TIMEOUT = 255;

endpackage

// File: rtl/bus_watchdog.sv
// Wait-cycle counter for an outstanding bus transaction; flags expiry on the last allowed cycle.
module bus_watchdog
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] count;

  // Count un-acked wait cycles; restart whenever a new transaction is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CntW'(1);
    end
  end

  // Expiry is seen during the TIMEOUT-th wait cycle, so the abort lands on that cycle's edge.
  assign expired = enable && (count == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bridge.sv
// Memory bridge between the multicycle control FSM and a req/ack memory bus.
// Holds IR and MDR; stalls control while a transaction is outstanding.
// Optional transaction timeout: define MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iOrD,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              irWrite,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] aluOut,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] memData,
  output logic              stall,
  output logic              busReq,
  output logic              busWe,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busWdata,
  input  logic              busAck,
  input  logic [DATA_W-1:0] busRdata,
  output logic              busErr
);

  bridge_state_e state;
  logic          irLatched;
  logic          start;
  logic          expired;

  assign start = memRead | memWrite;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic wdClear;
  logic wdEnable;

  assign wdClear  = (state == StIdle) & start;
  assign wdEnable = (state == StWait) & ~busAck;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wdClear),
    .enable (wdEnable),
    .expired(expired)
  );
`else
  logic [31:0] unusedTimeout;

  assign unusedTimeout = 32'(TIMEOUT);
  assign expired       = 1'b0;
  assign busErr        = 1'b0;
`endif

  // Bridge FSM: latch a request in idle, complete it on ack (or abort on timeout).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      busReq    <= 1'b0;
      busWe     <= 1'b0;
      busAddr   <= '0;
      busWdata  <= '0;
      irLatched <= 1'b0;
      instr     <= '0;
      memData   <= '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      busErr    <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            state     <= StWait;
            busReq    <= 1'b1;
            busWe     <= memWrite;
            busAddr   <= iOrD ? aluOut : pc;
            busWdata  <= writeData;
            // A write beats a simultaneous read, so the IR load is dropped with it.
            irLatched <= irWrite & ~memWrite;
          end
        end
        StWait: begin
          if (busAck) begin
            state  <= StIdle;
            busReq <= 1'b0;
            if (!busWe) begin
              memData <= busRdata;
              if (irLatched) instr <= busRdata;
            end
          end else if (expired) begin
            state  <= StIdle;
            busReq <= 1'b0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            busErr <= 1'b1;
`endif
            if (!busWe) begin
              memData <= DATA_W'(NOP_WORD);
              if (irLatched) instr <= DATA_W'(NOP_WORD);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Hold control while a request is pending or un-acked; release on ack or expiry.
  always_comb begin
    stall = 1'b0;
    case (state)
      StIdle:  stall = start;
      StWait:  stall = ~busAck & ~expired;
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Randomized self-checking bench for mem_bridge against a transaction-level model.
module tb_mem_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iOrD, memRead, memWrite, irWrite, busAck;
  logic [31:0] pc, aluOut, writeData, busRdata;
  logic [31:0] instr, memData, busAddr, busWdata;
  logic        stall, busReq, busWe, busErr;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state: architectural registers and the sticky error flag.
  logic [31:0] irModel  = '0;
  logic [31:0] mdrModel = '0;
  logic        errModel = 1'b0;

  mem_bridge #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iOrD     (iOrD),
    .memRead  (memRead),
    .memWrite (memWrite),
    .irWrite  (irWrite),
    .pc       (pc),
    .aluOut   (aluOut),
    .writeData(writeData),
    .instr    (instr),
    .memData  (memData),
    .stall    (stall),
    .busReq   (busReq),
    .busWe    (busWe),
    .busAddr  (busAddr),
    .busWdata (busWdata),
    .busAck   (busAck),
    .busRdata (busRdata),
    .busErr   (busErr)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkEq({tag, ".instr"}, instr, irModel);
    checkEq({tag, ".memData"}, memData, mdrModel);
    checkEq({tag, ".busErr"}, busErr, errModel);
  endtask

  // Idle cycles with stray acks that must be ignored.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      memRead  = 1'b0;
      memWrite = 1'b0;
      busAck   = 1'($urandom);
      busRdata = $urandom;
      @(negedge clk);
      checkEq("idle.busReq", busReq, 1'b0);
      checkEq("idle.stall", stall, 1'b0);
      checkRegs("idle");
      @(posedge clk); #1;
      busAck = 1'b0;
    end
  endtask

  // One complete transaction; ack arrives after `delay` un-acked wait cycles.
  // Called at posedge+1 with the bridge idle.
  task automatic doTxn(input logic rd, input logic wr, input logic iord, input logic irw,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int delay);
    logic [31:0] expAddr;
    int          stallCycles;
    expAddr   = iord ? a : p;
    memRead   = rd;
    memWrite  = wr;
    iOrD      = iord;
    irWrite   = irw;
    pc        = p;
    aluOut    = a;
    writeData = wd;
    stallCycles = 0;
    @(negedge clk);
    checkEq("req.busReq", busReq, 1'b0);
    if (stall) stallCycles++;
    @(posedge clk); #1;
    // Control holds the request; scramble datapath inputs to prove the bus is latched.
    pc        = $urandom;
    aluOut    = $urandom;
    writeData = $urandom;
    iOrD      = 1'($urandom);
    irWrite   = 1'($urandom);
    for (int i = 0; i < delay; i++) begin
      busRdata = $urandom;
      @(negedge clk);
      checkEq("wait.busReq", busReq, 1'b1);
      checkEq("wait.busAddr", busAddr, expAddr);
      checkEq("wait.busWe", busWe, wr);
      checkEq("wait.busWdata", busWdata, wd);
      checkEq("wait.busErr", busErr, errModel);
      if (stall) stallCycles++;
      @(posedge clk); #1;
    end
    busAck   = 1'b1;
    busRdata = rdat;
    @(negedge clk);
    checkEq("ack.busReq", busReq, 1'b1);
    checkEq("ack.busAddr", busAddr, expAddr);
    checkEq("ack.busWe", busWe, wr);
    checkEq("ack.stall", stall, 1'b0);
    @(posedge clk); #1;
    busAck   = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    if (rd && !wr) begin
      mdrModel = rdat;
      if (irw) irModel = rdat;
    end
    checkEq("done.busReq", busReq, 1'b0);
    checkEq("done.stallCycles", stallCycles, 1 + delay);
    checkRegs("done");
  endtask

  initial begin
    rst = 1'b1; iOrD = 1'b0; memRead = 1'b0; memWrite = 1'b0; irWrite = 1'b0;
    pc = '0; aluOut = '0; writeData = '0; busAck = 1'b0; busRdata = '0;
    @(posedge clk); @(posedge clk); #1;
    checkEq("reset.busReq", busReq, 1'b0);
    checkEq("reset.busWe", busWe, 1'b0);
    checkEq("reset.busAddr", busAddr, 32'h0);
    checkEq("reset.busWdata", busWdata, 32'h0);
    checkRegs("reset");
    rst = 1'b0;
    idleCycles(2);

    // Fetch: 3 cycles of no ack -> 4 stall cycles.
    doTxn(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 32'h2008_0005, 3);
    checkEq("fetch.instr", instr, 32'h2008_0005);
    // Load with minimum latency; IR must stay.
    doTxn(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    checkEq("load.instr", instr, 32'h2008_0005);
    // Store leaves IR/MDR untouched.
    doTxn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h104, 32'h1234, 32'h5555_AAAA, 1);
    // Read+write conflict: only the write happens, even with irWrite set.
    doTxn(1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h200, 32'hCAFE, 32'h7777_1111, 2);
    checkEq("conflict.memData", memData, 32'hDEAD_BEEF);
    idleCycles(1);

    // Random mix of reads, writes and conflicts with variable ack delay.
    for (int t = 0; t < 40; t++) begin
      int op;
      op = int'($urandom_range(0, 2));
      doTxn(op != 1, op != 0, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
            $urandom, int'($urandom_range(0, TO - 1)));
      idleCycles(int'($urandom_range(0, 2)));
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    // Fetch with no ack: aborted after TO wait cycles, loads a NOP, error sticks.
    memRead = 1'b1; irWrite = 1'b1; iOrD = 1'b0; pc = 32'h80;
    @(posedge clk); #1;
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk);
      checkEq("to.busReq", busReq, 1'b1);
      checkEq("to.stall", stall, (i == int'(TO) - 1) ? 1'b0 : 1'b1);
      @(posedge clk); #1;
    end
    memRead = 1'b0;
    irModel = 32'h0; mdrModel = 32'h0; errModel = 1'b1;
    checkEq("to.busReqDrop", busReq, 1'b0);
    checkRegs("to");
    idleCycles(2);
    doTxn(1'b1, 1'b0, 1'b0, 1'b1, 32'h84, 32'h0, 32'h0, 32'h1357_9BDF, 1);
`else
    // No timeout: a 1000-cycle wait stalls throughout and never flags an error.
    doTxn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 32'h0BAD_F00D, 1000);
`endif

    // Async reset during WAIT: busReq drops before the next edge.
    memRead = 1'b1; memWrite = 1'b0; irWrite = 1'b1; iOrD = 1'b0; pc = 32'h44;
    @(posedge clk); #1;
    checkEq("rstw.busReqBefore", busReq, 1'b1);
    #2 rst = 1'b1;
    #1;
    irModel = '0; mdrModel = '0; errModel = 1'b0;
    checkEq("rstw.busReq", busReq, 1'b0);
    checkEq("rstw.busAddr", busAddr, 32'h0);
    checkEq("rstw.busWe", busWe, 1'b0);
    checkEq("rstw.busWdata", busWdata, 32'h0);
    checkRegs("rstw");
    memRead = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idleCycles(3);
    doTxn(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h48, 32'h0, 32'h2468_ACE0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
